// File: rtl/mat_serializer.sv
// Purpose: streams a captured H x W matrix out one S-bit element per cycle, row-major.
// Latency: load sampled at edge N -> element (0,0) valid after edge N; 1 element/cycle.
// Backpressure: outputs hold while out_ready is low; loads during a transfer are dropped (overrun).
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   load, mat              capture request and flat matrix bus, (0,0) in the top S bits
//   out_data/row/col/last  current element, its position, last-element flag
//   out_valid, out_ready   stream handshake
//   busy                   a matrix is held and not fully sent
//   overrun                sticky flag: a load was dropped while busy
module mat_serializer #(
  parameter int S  = 32,
  parameter int H  = 2,
  parameter int W  = 2,
  localparam int RB = (H > 1) ? $clog2(H) : 1,
  localparam int CB = (W > 1) ? $clog2(W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [H*W*S-1:0] mat,
  output logic [S-1:0]     out_data,
  output logic [RB-1:0]    out_row,
  output logic [CB-1:0]    out_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [H*W*S-1:0] mat_q;

  logic             col_wrap;
  logic [RB-1:0]    nxt_row;
  logic [CB-1:0]    nxt_col;
  logic             nxt_last;
  logic [S-1:0]     nxt_elem;
  logic [S-1:0]     first_elem;
  logic             take;

  // Element (r,c) of a flat bus; out-of-range positions (only reachable as the
  // unused successor of the last element) fold to index 0.
  function automatic logic [S-1:0] elem(input logic [H*W*S-1:0] m,
                                        input logic [RB-1:0] r,
                                        input logic [CB-1:0] c);
    int idx;
    idx = int'(r) * W + int'(c);
    if (idx >= H * W) idx = 0;
    return m[(H*W-1-idx)*S +: S];
  endfunction

  always_comb begin
    col_wrap   = (out_col == CB'(W - 1));
    nxt_col    = col_wrap ? '0 : out_col + CB'(1);
    nxt_row    = col_wrap ? out_row + RB'(1) : out_row;
    nxt_last   = (nxt_row == RB'(H - 1)) && (nxt_col == CB'(W - 1));
    nxt_elem   = elem(mat_q, nxt_row, nxt_col);
    first_elem = elem(mat, '0, '0);
    // A load is accepted when idle, or when it coincides with the final
    // handshake so the next matrix follows with no bubble.
    take       = load && ((state == IDLE) || (out_ready && out_last));
  end

  // Outputs are all registered, so out_valid never depends on out_ready
  // combinationally and every stream output is stable until its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mat_q     <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (take) begin
        state     <= SEND;
        mat_q     <= mat;
        out_data  <= first_elem;
        out_row   <= '0;
        out_col   <= '0;
        out_valid <= 1'b1;
        out_last  <= (H * W == 1);
        busy      <= 1'b1;
      end else if ((state == SEND) && out_ready) begin
        if (out_last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end else begin
          out_data <= nxt_elem;
          out_row  <= nxt_row;
          out_col  <= nxt_col;
          out_last <= nxt_last;
        end
      end
      if (load && !take) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mat_serializer.sv
// Purpose: directed bench for mat_serializer in 2x2, 1x1 and 2x3 shapes.
// Latency: expects element (0,0) one edge after load, one element per handshake.
// Backpressure: scoreboard pops only on valid&ready; held outputs are compared while ready is low.
module tb_mat_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    logic        l;
  } exp_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- 2x2 instance ----------------
  logic         ld22 = 1'b0, rdy22 = 1'b0;
  logic [127:0] mat22 = '0;
  logic [31:0]  d22;
  logic [0:0]   r22, c22;
  logic         v22, l22, b22, o22;

  mat_serializer #(.S(32), .H(2), .W(2)) u22 (
    .clk(clk), .rst_n(rst_n), .load(ld22), .mat(mat22),
    .out_data(d22), .out_row(r22), .out_col(c22), .out_valid(v22),
    .out_ready(rdy22), .out_last(l22), .busy(b22), .overrun(o22));

  // ---------------- 1x1 instance ----------------
  logic        ld11 = 1'b0, rdy11 = 1'b0;
  logic [31:0] mat11 = '0;
  logic [31:0] d11;
  logic [0:0]  r11, c11;
  logic        v11, l11, b11, o11;

  mat_serializer #(.S(32), .H(1), .W(1)) u11 (
    .clk(clk), .rst_n(rst_n), .load(ld11), .mat(mat11),
    .out_data(d11), .out_row(r11), .out_col(c11), .out_valid(v11),
    .out_ready(rdy11), .out_last(l11), .busy(b11), .overrun(o11));

  // ---------------- 2x3 instance ----------------
  logic         ld23 = 1'b0, rdy23 = 1'b0;
  logic [191:0] mat23 = '0;
  logic [31:0]  d23;
  logic [0:0]   r23;
  logic [1:0]   c23;
  logic         v23, l23, b23, o23;

  mat_serializer #(.S(32), .H(2), .W(3)) u23 (
    .clk(clk), .rst_n(rst_n), .load(ld23), .mat(mat23),
    .out_data(d23), .out_row(r23), .out_col(c23), .out_valid(v23),
    .out_ready(rdy23), .out_last(l23), .busy(b23), .overrun(o23));

  exp_t q22[$];
  exp_t q11[$];
  exp_t q23[$];
  int   hs22 = 0;

  task automatic push22(input logic [127:0] m);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = m[(3 - i) * 32 +: 32];
      e.r = i / 2;
      e.c = i % 2;
      e.l = (i == 3);
      q22.push_back(e);
    end
  endtask

  task automatic push23(input logic [191:0] m);
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.d = m[(5 - i) * 32 +: 32];
      e.r = i / 3;
      e.c = i % 3;
      e.l = (i == 5);
      q23.push_back(e);
    end
  endtask

  // Monitors sample on the falling edge, where inputs and outputs are settled
  // and equal to what the next rising edge will see.
  logic        hold_pend = 1'b0;
  logic [31:0] hold_d;
  logic [0:0]  hold_r, hold_c;
  logic        hold_l;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        chk("hold_valid", v22, 1'b1);
        chk("hold_data", d22, hold_d);
        chk("hold_row", r22, hold_r);
        chk("hold_col", c22, hold_c);
        chk("hold_last", l22, hold_l);
      end
      hold_pend = v22 && !rdy22;
      hold_d = d22; hold_r = r22; hold_c = c22; hold_l = l22;
      if (v22 && rdy22) begin
        hs22++;
        if (q22.size() == 0) begin
          total++; bad++;
          $error("FAIL d22_unexpected observed data=%0h expected none", d22);
        end else begin
          exp_t e;
          e = q22.pop_front();
          chk("d22_data", d22, e.d);
          chk("d22_row", r22, e.r);
          chk("d22_col", c22, e.c);
          chk("d22_last", l22, e.l);
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && v11 && rdy11) begin
      if (q11.size() == 0) begin
        total++; bad++;
        $error("FAIL d11_unexpected observed data=%0h expected none", d11);
      end else begin
        exp_t e;
        e = q11.pop_front();
        chk("d11_data", d11, e.d);
        chk("d11_row", r11, e.r);
        chk("d11_col", c11, e.c);
        chk("d11_last", l11, e.l);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v23 && rdy23) begin
      if (q23.size() == 0) begin
        total++; bad++;
        $error("FAIL d23_unexpected observed data=%0h expected none", d23);
      end else begin
        exp_t e;
        e = q23.pop_front();
        chk("d23_data", d23, e.d);
        chk("d23_row", r23, e.r);
        chk("d23_col", c23, e.c);
        chk("d23_last", l23, e.l);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((q22.size() + q11.size() + q23.size()) != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, q22.size() + q11.size() + q23.size(), 0);
  endtask

  localparam logic [127:0] MA = {32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
  localparam logic [127:0] MB = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
  localparam logic [127:0] MC = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [191:0] M23 = {32'h3f1d8a2c, 32'hbe9c4f10, 32'h3e2a7b55,
                                  32'h3fa6c301, 32'hbf364b07, 32'h40120e9d};

  initial begin
    int hs_before;
    exp_t e1;

    // Reset state
    #3;
    chk("rst_valid", v22, 1'b0);
    chk("rst_last", l22, 1'b0);
    chk("rst_busy", b22, 1'b0);
    chk("rst_overrun", o22, 1'b0);
    chk("rst_data", d22, 32'h0);
    chk("rst_rowcol", {r22, c22}, 2'b00);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic stream, ready high; mat changed after capture must not matter
    mat22 = MA; push22(MA); ld22 = 1'b1; rdy22 = 1'b1;
    cyc();
    ld22 = 1'b0; mat22 = MB;
    chk("basic_latency_valid", v22, 1'b1);
    chk("basic_first_data", d22, 32'h3f800000);
    chk("basic_busy", b22, 1'b1);
    repeat (4) cyc();
    chk("basic_busy_fall", b22, 1'b0);
    chk("basic_valid_fall", v22, 1'b0);
    drain("basic_drain", 4);

    // Backpressure pattern
    mat22 = MA; push22(MA); ld22 = 1'b1; rdy22 = 1'b0;
    cyc();
    ld22 = 1'b0;
    hs_before = hs22;
    foreach (MB[i]) begin end
    rdy22 = 1'b1; cyc();
    rdy22 = 1'b0; cyc();
    rdy22 = 1'b0; cyc();
    rdy22 = 1'b1; cyc();
    rdy22 = 1'b1; cyc();
    rdy22 = 1'b0; cyc();
    rdy22 = 1'b1; cyc();
    chk("bp_handshakes", hs22 - hs_before, 4);
    chk("bp_busy_end", b22, 1'b0);
    drain("bp_drain", 4);

    // Overrun: B offered during A's 2nd element is dropped
    mat22 = MA; push22(MA); ld22 = 1'b1; rdy22 = 1'b1;
    cyc();
    ld22 = 1'b0;
    cyc();
    chk("ovr_before", o22, 1'b0);
    mat22 = MB; ld22 = 1'b1;
    cyc();
    ld22 = 1'b0;
    chk("ovr_set", o22, 1'b1);
    repeat (4) cyc();
    chk("ovr_sticky", o22, 1'b1);
    chk("ovr_idle_valid", v22, 1'b0);
    drain("ovr_drain", 4);

    // Reset mid-stream after 2 of 4 elements
    mat22 = MC; push22(MC); ld22 = 1'b1; rdy22 = 1'b1;
    cyc();
    ld22 = 1'b0;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    q22.delete();
    chk("mrst_valid", v22, 1'b0);
    chk("mrst_data", d22, 32'h0);
    chk("mrst_rowcol", {r22, c22}, 2'b00);
    chk("mrst_busy", b22, 1'b0);
    chk("mrst_overrun", o22, 1'b0);
    chk("mrst_last", l22, 1'b0);
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("mrst_quiet", v22, 1'b0);
    end
    mat22 = MB; push22(MB); ld22 = 1'b1;
    cyc();
    ld22 = 1'b0;
    chk("mrst_restart_row", r22, 1'b0);
    chk("mrst_restart_data", d22, 32'hdeadbeef);
    drain("mrst_drain", 6);

    // Back-to-back: B loaded on A's last handshake
    mat22 = MA; push22(MA); ld22 = 1'b1; rdy22 = 1'b1;
    cyc();
    ld22 = 1'b0;
    repeat (3) begin
      cyc();
      chk("b2b_busy_a", b22, 1'b1);
    end
    chk("b2b_last_shown", l22, 1'b1);
    mat22 = MB; push22(MB); ld22 = 1'b1;
    cyc();
    ld22 = 1'b0;
    chk("b2b_valid", v22, 1'b1);
    chk("b2b_busy", b22, 1'b1);
    chk("b2b_first", d22, 32'hdeadbeef);
    repeat (3) begin
      cyc();
      chk("b2b_busy_b", b22, 1'b1);
    end
    cyc();
    chk("b2b_overrun", o22, 1'b0);
    chk("b2b_done", b22, 1'b0);
    drain("b2b_drain", 4);

    // 1x1: single element, first is last
    mat11 = 32'hc01163de;
    e1.d = 32'hc01163de; e1.r = 0; e1.c = 0; e1.l = 1'b1;
    q11.push_back(e1);
    ld11 = 1'b1; rdy11 = 1'b1;
    cyc();
    ld11 = 1'b0;
    chk("d11_last_now", l11, 1'b1);
    chk("d11_valid_now", v11, 1'b1);
    cyc();
    chk("d11_busy_fall", b11, 1'b0);
    drain("d11_drain", 4);

    // 2x3: row-major order, element (1,1) = bf364b07
    mat23 = M23; push23(M23); ld23 = 1'b1; rdy23 = 1'b1;
    cyc();
    ld23 = 1'b0;
    repeat (4) cyc();
    chk("d23_elem11", d23, 32'hbf364b07);
    chk("d23_pos11", {r23, c23}, 3'b101);
    drain("d23_drain", 8);
    cyc();
    chk("d23_busy_fall", b23, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
